// File: rtl/controller_pkg.sv
// controller_pkg: shared types, opcode/ALU/mux encodings and Moore output decode for the multicycle controller
package controller_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ILLEGAL
    } state_t;

    // Opcodes are kept as plain integers; users zero-extend them to their OP_W.
    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_LW  = 4;
    localparam int unsigned OP_SW  = 5;
    localparam int unsigned OP_BEQ = 6;
    localparam int unsigned OP_J   = 7;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_OFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       memwrite;
        logic       regwrite;
    } ctl_t;

    // Ungated Moore outputs for a state; alu_exec is only used in EXEC.
    function automatic ctl_t moore_ctl(input state_t s, input logic [2:0] alu_exec);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrcb    = SRCB_ONE;
                c.alucontrol = ALU_ADD;
                c.pcsrc      = PC_ALU;
            end
            DECODE: begin
                c.alusrcb    = SRCB_OFF;
                c.alucontrol = ALU_ADD;
            end
            MEMADR: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_IMM;
                c.alucontrol = ALU_ADD;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXEC: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_REG;
                c.alucontrol = alu_exec;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_REG;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = PC_ALUOUT;
            end
            JUMP: c.pcsrc = PC_JUMP;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: opcode to ALU operation mapping used by the EXEC state
//   op         in  OP_W  opcode (ADD/SUB/AND/OR meaningful; anything else decodes to ADD)
//   alucontrol out 3     ALU operation code
module mc_aludec
    import controller_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op,
    output logic [2:0]      alucontrol
);

    always_comb
        alucontrol = op == OP_W'(OP_SUB) ? ALU_SUB :
                     op == OP_W'(OP_AND) ? ALU_AND :
                     op == OP_W'(OP_OR)  ? ALU_OR  : ALU_ADD;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/writeback with memory wait and illegal-opcode trap
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op                    opcode (sampled only in DECODE and MEMADR)
//   zero                  ALU zero flag (gates pcwrite in BRANCH)
//   mem_ready             memory access completes this cycle (FETCH, MEMRD, MEMWR)
//   irwrite, pcwrite      IR / PC load strobes
//   iord, memwrite        memory address select and write strobe
//   memtoreg, regwrite    register write data select and write strobe
//   regdst                destination field select (1 = rd)
//   alusrca, alusrcb      ALU operand selects
//   pcsrc, alucontrol     PC source select and ALU operation
//   illegal               sticky illegal-opcode flag
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            irwrite,
    output logic            pcwrite,
    output logic            iord,
    output logic            memwrite,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            regdst,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [2:0]      alucontrol,
    output logic            illegal
);

    state_t     state_q, state_d;
    ctl_t       ctl_q;
    logic       illegal_q;
    logic [2:0] alu_exec;

    mc_aludec #(.OP_W(OP_W)) u_aludec (
        .op         (op),
        .alucontrol (alu_exec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: state_d = op <  OP_W'(OP_LW)  ? EXEC   :
                              op <= OP_W'(OP_SW)  ? MEMADR :
                              op == OP_W'(OP_BEQ) ? BRANCH :
                              op == OP_W'(OP_J)   ? JUMP   : ILLEGAL;
            MEMADR: state_d = op == OP_W'(OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            MEMWB, ALUWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = ILLEGAL;
        endcase
    end

    // Moore outputs are registered from the next state, so EXEC's ALU code
    // captures op as seen during DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ctl_q     <= moore_ctl(FETCH, ALU_ADD);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= moore_ctl(state_d, alu_exec);
            illegal_q <= illegal_q | (state_d == ILLEGAL);
        end
    end

    // Strobes depend on live inputs and are killed while reset is high.
    assign irwrite    = ~reset & mem_ready & (state_q == FETCH);
    assign pcwrite    = ~reset & ((mem_ready & (state_q == FETCH)) |
                                  (zero & (state_q == BRANCH)) |
                                  (state_q == JUMP));
    assign memwrite   = ~reset & ctl_q.memwrite;
    assign regwrite   = ~reset & ctl_q.regwrite;
    assign iord       = ctl_q.iord;
    assign memtoreg   = ctl_q.memtoreg;
    assign regdst     = ctl_q.regdst;
    assign alusrca    = ctl_q.alusrca;
    assign alusrcb    = ctl_q.alusrcb;
    assign pcsrc      = ctl_q.pcsrc;
    assign alucontrol = ctl_q.alucontrol;
    assign illegal    = illegal_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the 4-bit CPU datapath, replacing the single-cycle controller. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback, sharing one ALU and one memory port. Opcode width is parametrised. The block adds a memory-ready wait handshake and illegal-opcode trapping.

## Interface
- OP_W, 3, opcode width; OP_W ≥ 3; codes are compared on all OP_W bits, upper bits must be 0
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- op  in  OP_W  opcode from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- irwrite  out  1  load the instruction register
- pcwrite  out  1  load the PC (already includes the branch condition)
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- memtoreg  out  1  register write data source: 1 = memory data register
- regwrite  out  1  register file write strobe
- regdst  out  1  destination register field select: 1 = rd
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B input: 00 = register B, 01 = constant 1, 10 = immediate, 11 = branch offset
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- illegal  out  1  sticky illegal-opcode flag

## Operation
- Opcodes:
  - ADD = 0, SUB = 1, AND = 2, OR = 3
  - LW = 4, SW = 5, BEQ = 6, J = 7
  - Any other value is illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ILLEGAL.
- Outputs are Moore, decoded from the state. The exceptions are gated strobes: irwrite and pcwrite in FETCH, and pcwrite in BRANCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: iord = 0, alusrca = 0, alusrcb = 01, alucontrol = ADD, pcsrc = 00, irwrite = pcwrite = mem_ready.
  - Transition: go to DECODE when mem_ready = 1, otherwise stay in FETCH.
- DECODE:
  - Outputs: alusrca = 0, alusrcb = 11, alucontrol = ADD.
  - Transition by opcode: ADD/SUB/AND/OR go to EXEC; LW/SW go to MEMADR; BEQ goes to BRANCH; J goes to JUMP; anything else goes to ILLEGAL.
- MEMADR:
  - Outputs: alusrca = 1, alusrcb = 10, alucontrol = ADD.
  - Transition: LW goes to MEMRD, SW goes to MEMWR.
- MEMRD:
  - Outputs: iord = 1.
  - Transition: go to MEMWB when mem_ready = 1, otherwise stay.
- MEMWB:
  - Outputs: memtoreg = 1, regdst = 0, regwrite = 1.
  - Transition: go to FETCH.
- MEMWR:
  - Outputs: iord = 1, memwrite = 1 for every cycle spent in this state.
  - Transition: go to FETCH when mem_ready = 1, otherwise stay.
- EXEC:
  - Outputs: alusrca = 1, alusrcb = 00, alucontrol = the ALU code for the opcode.
  - Transition: go to ALUWB.
- ALUWB:
  - Outputs: regdst = 1, memtoreg = 0, regwrite = 1.
  - Transition: go to FETCH.
- BRANCH:
  - Outputs: alusrca = 1, alusrcb = 00, alucontrol = SUB, pcsrc = 01, pcwrite = zero.
  - Transition: go to FETCH.
- JUMP:
  - Outputs: pcsrc = 10, pcwrite = 1.
  - Transition: go to FETCH.
- ILLEGAL:
  - Outputs: all strobes 0, illegal = 1.
  - Transition: stays in ILLEGAL until reset.
- ALU codes: ADD = 010, SUB = 110, AND = 000, OR = 001.
- The op input is sampled only in DECODE and MEMADR. Its value in any other state has no effect.

## Timing
- Reset:
  - Next state is FETCH, and the illegal flag is cleared.
  - While reset = 1, the strobes irwrite, pcwrite, memwrite and regwrite are forced to 0 in every state.
  - Reset has priority in every state, including mid-wait in MEMRD/MEMWR and in ILLEGAL.
- Cycles per instruction with mem_ready tied to 1:
  - ALU ops: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- A mem_ready pulse in a state with no memory access is ignored.
- BEQ: pcwrite follows the combinational value of zero during the BRANCH cycle only.
- illegal rises on the first cycle in ILLEGAL and stays high.

## Structure
- Package controller_pkg holds:
  - state_t enum
  - opcode localparams, zero-extended to OP_W
  - ALU control codes
  - alusrcb and pcsrc encodings
- Sub-module mc_aludec: combinational mapping from opcode to alucontrol, used in EXEC.
- Top level: state register, next-state logic, output decode.

## Test plan
- Reset held for 2 cycles with mem_ready = 1 -> all strobes 0 during reset; the first cycle after reset is FETCH with irwrite = pcwrite = 1.
- ADD (op = 0), mem_ready = 1 -> 4 cycles.
  - EXEC cycle: alucontrol = 010, alusrca = 1, alusrcb = 00.
  - ALUWB cycle: regwrite = 1, regdst = 1.
  - Then back to FETCH.
- LW with mem_ready low for 2 cycles in MEMRD -> 7 cycles total; iord = 1 for 3 cycles; regwrite = 1 and memtoreg = 1 in the final cycle.
- BEQ with zero = 1 -> pcwrite = 1 and pcsrc = 01 in BRANCH. Repeat with zero = 0 -> pcwrite stays 0.
- SW with mem_ready stalled 1 cycle -> memwrite = 1 for 2 cycles, then FETCH.
- OP_W = 4, op = 4'b1000 -> DECODE goes to ILLEGAL; illegal = 1 and stays high for 10 cycles with no strobes; reset returns to FETCH with illegal = 0.
